fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
- Frame-level scheduler that shares one 256-point FFT_256 core between two requesters: ch0 (forward FFT) and ch1 (inverse FFT).
- Arbitrates requests round-robin and streams the granted channel's 256-sample frame into the core.
- For ch1, applies conjugation on the way in and conjugate plus >>LOG2N on the way out.
- Counts core outputs, tags them with channel and frame-last, and supervises the core with a drain watchdog.

Parameters:
- N, 256, samples per frame
- LOG2N, 8, counter width and inverse scaling shift
- DW, 16, signed sample width (real and imag each)
- TIMEOUT, 4096, max DRAIN cycles without frame completion before abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-channel frame request, level; bit0 = FFT, bit1 = IFFT
- gnt  out  2  one-hot grant; held for the whole LOAD phase
- ch_valid  in  2  per-channel sample valid; only the granted bit is used
- ch0_real, ch0_img  in  DW each  ch0 sample, signed
- ch1_real, ch1_img  in  DW each  ch1 sample, signed
- core_in_valid  out  1  to core in_valid
- core_x_real, core_x_img  out  DW each  to core inputs
- core_out_valid  in  1  from core out_valid
- core_y_real, core_y_img  in  DW each  from core outputs
- o_valid  out  1  result valid
- o_real, o_img  out  DW each  result sample
- o_ch  out  1  channel of the current result
- o_last  out  1  high with the Nth result of a frame
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse: timeout or unexpected core output

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=0 (ch0 wins first tie), counters=0. gnt, core_in_valid, core_x_*, o_valid, o_real, o_img, o_ch, o_last, busy, err all 0.
- States:
  - IDLE: if any req, grant per round-robin (single request wins directly; on tie, pointer channel wins); register active channel; go to LOAD. gnt asserts the cycle after entry to LOAD is decided (registered).
  - LOAD: core_in_valid = ch_valid[active] (combinational pass-through). in_cnt increments per accepted sample; gaps are forwarded as core_in_valid=0. On the Nth accepted sample, gnt drops the next cycle and state goes to DRAIN; in_cnt clears.
  - DRAIN: out_cnt increments on each core_out_valid. After the Nth result, return to IDLE and flip the rr pointer to the other channel. wd_cnt counts DRAIN cycles; on reaching TIMEOUT: pulse err, go to IDLE, flip pointer, no o_last.
- Input transform, combinational in LOAD:
  - ch0: x passed unchanged.
  - ch1: real unchanged; imag negated with saturation (-32768 becomes 32767).
  - Outside LOAD, core_x_* = 0.
- Output, registered, 1 cycle after core_out_valid in DRAIN:
  - ch0: o = y.
  - ch1: o_real = y_real >>> LOG2N; o_img = (-y_img, saturated) >>> LOG2N. Shifts are arithmetic and sign-preserving.
  - o_ch = active channel; o_last on the result for out_cnt==N-1.
  - o_valid is 0 otherwise; data holds its last value.
- core_out_valid in IDLE or LOAD: ignored (no o_valid), err pulses.
- Only one frame is in flight; no new grant until DRAIN exits.
- A req drop during LOAD does not cancel the frame.
- Reset mid-frame: immediate return to reset values; core state is the core's own concern.
- busy is high in LOAD and DRAIN.

Decomposition:
- Shared package fft_sched_pkg holds: state encoding (IDLE=0, LOAD=1, DRAIN=2), N/LOG2N/DW defaults, channel ids CH_FFT=0 and CH_IFFT=1.
- One natural sub-module: fft_conj_scale. It performs the combinational saturating conjugate plus optional arithmetic shift and is instantiated for the input and output paths.

Test Plan:
- Single FFT frame: req=01, 256 contiguous samples x=(k, 0) -> gnt=01 for exactly 256 accepted samples; core sees identical data; 256 o_valid with o_ch=0; o_last on the 256th; busy falls after it.
- IFFT transform: req=10, sample (100, 5) -> core_x=(100, -5). Core output (25600, 512) -> o=(100, -2). Input imag -32768 -> core_x_img 32767.
- Arbitration: req=11 from reset -> ch0 frame, then ch1, then ch0. No gnt while busy=1; gnt is never 11.
- Input gaps: ch_valid toggled 50% during LOAD -> core_in_valid mirrors it; DRAIN entered only after the 256th valid.
- Watchdog: core returns only 10 outputs -> err pulses once at DRAIN cycle TIMEOUT; state goes to IDLE; next req granted normally.
- Reset mid-LOAD at sample 100 -> all outputs 0 asynchronously. After release, a fresh frame is accepted with in_cnt starting at 0 and ch0 priority.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared state encoding, default sizes and channel ids for the FFT frame scheduler
package fft_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;
  localparam int FFT_N = 256;
  localparam int FFT_LOG2N = 8;
  localparam int FFT_DW = 16;
  localparam logic CH_FFT = 1'b0;
  localparam logic CH_IFFT = 1'b1;
endpackage

// File: rtl/fft_conj_scale.sv
// fft_conj_scale: saturating complex conjugate with optional arithmetic right shift
module fft_conj_scale #(
  parameter int DW = 16,
  parameter int SH = 8
) (
  input  logic signed [DW-1:0] i_real,
  input  logic signed [DW-1:0] i_img,
  input  logic                 i_conj,
  input  logic                 i_shift,
  output logic signed [DW-1:0] o_real,
  output logic signed [DW-1:0] o_img
);
  localparam logic signed [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX = {1'b0, {(DW-1){1'b1}}};
  logic signed [DW-1:0] w_img;
  // negating the most negative value would wrap, so clamp it to the positive limit
  assign w_img = !i_conj ? i_img : (i_img == MIN) ? MAX : -i_img;
  assign o_real = i_shift ? i_real >>> SH : i_real;
  assign o_img = i_shift ? w_img >>> SH : w_img;
endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: round-robin frame scheduler sharing one FFT core between a forward and an inverse channel
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW = FFT_DW,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  output logic [1:0]           gnt,
  input  logic [1:0]           ch_valid,
  input  logic signed [DW-1:0] ch0_real,
  input  logic signed [DW-1:0] ch0_img,
  input  logic signed [DW-1:0] ch1_real,
  input  logic signed [DW-1:0] ch1_img,
  output logic                 core_in_valid,
  output logic signed [DW-1:0] core_x_real,
  output logic signed [DW-1:0] core_x_img,
  input  logic                 core_out_valid,
  input  logic signed [DW-1:0] core_y_real,
  input  logic signed [DW-1:0] core_y_img,
  output logic                 o_valid,
  output logic signed [DW-1:0] o_real,
  output logic signed [DW-1:0] o_img,
  output logic                 o_ch,
  output logic                 o_last,
  output logic                 busy,
  output logic                 err
);
  localparam int WDW = $clog2(TIMEOUT);
  state_t r_state, w_next;
  logic r_rr, r_act, r_o_valid, r_o_ch, r_o_last, r_err;
  logic [1:0] r_gnt;
  logic [LOG2N-1:0] r_in_cnt, r_out_cnt;
  logic [WDW-1:0] r_wd_cnt;
  logic signed [DW-1:0] r_o_real, r_o_img;
  logic w_pick, w_start, w_acc, w_in_done, w_res, w_out_done, w_tmo, w_stray;
  logic signed [DW-1:0] w_ir, w_ii, w_xr, w_xi, w_yr, w_yi;

  assign w_pick = (req == 2'b10) ? CH_IFFT : (req == 2'b01) ? CH_FFT : r_rr;
  assign w_start = r_state == IDLE && |req;
  assign w_acc = r_state == LOAD && ch_valid[r_act];
  assign w_in_done = w_acc && r_in_cnt == LOG2N'(N - 1);
  assign w_res = r_state == DRAIN && core_out_valid;
  assign w_out_done = w_res && r_out_cnt == LOG2N'(N - 1);
  assign w_tmo = r_state == DRAIN && r_wd_cnt == WDW'(TIMEOUT - 1);
  assign w_stray = core_out_valid && r_state != DRAIN;

  assign w_ir = (r_act == CH_IFFT) ? ch1_real : ch0_real;
  assign w_ii = (r_act == CH_IFFT) ? ch1_img : ch0_img;

  fft_conj_scale #(.DW(DW), .SH(LOG2N)) u_in (
    .i_real(w_ir), .i_img(w_ii), .i_conj(r_act == CH_IFFT), .i_shift(1'b0),
    .o_real(w_xr), .o_img(w_xi)
  );

  fft_conj_scale #(.DW(DW), .SH(LOG2N)) u_out (
    .i_real(core_y_real), .i_img(core_y_img), .i_conj(r_act == CH_IFFT), .i_shift(r_act == CH_IFFT),
    .o_real(w_yr), .o_img(w_yi)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? LOAD : IDLE;
      LOAD:    w_next = w_in_done ? DRAIN : LOAD;
      DRAIN:   w_next = (w_out_done || w_tmo) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr <= CH_FFT;
      r_act <= CH_FFT;
      r_gnt <= 2'b00;
      r_in_cnt <= '0;
      r_out_cnt <= '0;
      r_wd_cnt <= '0;
      r_o_valid <= 1'b0;
      r_o_real <= '0;
      r_o_img <= '0;
      r_o_ch <= 1'b0;
      r_o_last <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_act <= w_pick;
        r_gnt <= (w_pick == CH_IFFT) ? 2'b10 : 2'b01;
      end
      if (w_in_done) r_gnt <= 2'b00;
      r_in_cnt <= w_in_done ? '0 : w_acc ? r_in_cnt + LOG2N'(1) : r_in_cnt;
      r_out_cnt <= (r_state != DRAIN) ? '0 : w_res ? r_out_cnt + LOG2N'(1) : r_out_cnt;
      r_wd_cnt <= (r_state == DRAIN) ? r_wd_cnt + WDW'(1) : '0;
      // the next tie goes to whichever channel was not just served
      if (r_state == DRAIN && w_next == IDLE) r_rr <= ~r_act;
      r_o_valid <= w_res;
      r_o_last <= w_out_done;
      r_err <= w_stray || (w_tmo && !w_out_done);
      if (w_res) begin
        r_o_real <= w_yr;
        r_o_img <= w_yi;
        r_o_ch <= r_act;
      end
    end

  assign gnt = r_gnt;
  assign busy = r_state != IDLE;
  assign core_in_valid = w_acc;
  assign core_x_real = (r_state == LOAD) ? w_xr : '0;
  assign core_x_img = (r_state == LOAD) ? w_xi : '0;
  assign o_valid = r_o_valid;
  assign o_real = r_o_real;
  assign o_img = r_o_img;
  assign o_ch = r_o_ch;
  assign o_last = r_o_last;
  assign err = r_err;
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: drives fft_frame_sched as both requesters and the FFT core, checking against a reference model
module tb_fft_frame_sched;
  localparam int N = 256;
  localparam int TIMEOUT = 4096;

  typedef struct {
    int xr, xi, exr, exi, yr, yi, eor, eoi;
  } vec_t;

  logic clk, rst_n;
  logic [1:0] req, gnt, ch_valid;
  logic signed [15:0] ch0_real, ch0_img, ch1_real, ch1_img;
  logic core_in_valid, core_out_valid;
  logic signed [15:0] core_x_real, core_x_img, core_y_real, core_y_img;
  logic o_valid, o_ch, o_last, busy, err;
  logic signed [15:0] o_real, o_img;

  int n_cmp = 0;
  int n_bad = 0;
  logic m_rr;
  vec_t tbl [6];

  fft_frame_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .ch_valid(ch_valid),
    .ch0_real(ch0_real), .ch0_img(ch0_img), .ch1_real(ch1_real), .ch1_img(ch1_img),
    .core_in_valid(core_in_valid), .core_x_real(core_x_real), .core_x_img(core_x_img),
    .core_out_valid(core_out_valid), .core_y_real(core_y_real), .core_y_img(core_y_img),
    .o_valid(o_valid), .o_real(o_real), .o_img(o_img), .o_ch(o_ch), .o_last(o_last),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_neg(input int v);
    return (-v > 32767) ? 32767 : -v;
  endfunction

  function automatic int floor256(input int v);
    return (v >= 0) ? v / 256 : -((-v + 255) / 256);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_in_valid"}, core_in_valid, 0);
    chk({tag, "_core_x_real"}, core_x_real, 0);
    chk({tag, "_core_x_img"}, core_x_img, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_real"}, o_real, 0);
    chk({tag, "_o_img"}, o_img, 0);
    chk({tag, "_o_ch"}, o_ch, 0);
    chk({tag, "_o_last"}, o_last, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // mode: 0 random data, 1 ramp x=(k,0), 2 table vectors for the first ch1 samples/results
  task automatic frame(input logic [1:0] rq, input int gap, input int nout, input int mode,
                       input bit drop, input int abort_at);
    logic ch;
    bit cv, v, tb;
    int k, t, d, got, er, ei;
    ch = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : m_rr;
    req = rq;
    t = 0;
    tick();
    while (gnt == 2'b00 && t < 20) begin
      tick();
      t++;
    end
    chk("grant", gnt, ch ? 2 : 1);
    chk("grant_latency", t, 0);
    chk("busy_load", busy, 1);
    k = 0;
    t = 0;
    while (k < N && t < N * 20) begin
      cv = $urandom_range(99) >= gap;
      ch_valid[ch] = cv;
      ch_valid[!ch] = 1'($urandom);
      ch0_real = 16'($urandom);
      ch0_img = 16'($urandom);
      ch1_real = 16'($urandom);
      ch1_img = 16'($urandom);
      tb = mode == 2 && ch && k < 6;
      if (mode == 1 && !ch) begin
        ch0_real = 16'(k);
        ch0_img = 16'sd0;
      end else if (tb) begin
        ch1_real = 16'(tbl[k].xr);
        ch1_img = 16'(tbl[k].xi);
      end
      if (drop && k == 5) req = 2'b00;
      #1;
      chk("gnt_load", gnt, ch ? 2 : 1);
      chk("core_in_valid", core_in_valid, cv);
      if (cv) begin
        if (tb) begin
          er = tbl[k].exr;
          ei = tbl[k].exi;
        end else if (ch) begin
          er = ch1_real;
          ei = sat_neg(ch1_img);
        end else begin
          er = ch0_real;
          ei = ch0_img;
        end
        chk("core_x_real", core_x_real, er);
        chk("core_x_img", core_x_img, ei);
      end
      tick();
      t++;
      if (cv) k++;
      if (cv && k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        #2 rst_n = 1'b1;
        ch_valid = 2'b00;
        req = 2'b00;
        m_rr = 1'b0;
        return;
      end
    end
    if (t >= N * 20) chk("load_samples", k, N);
    ch_valid = 2'b00;
    chk("gnt_drop", gnt, 0);
    chk("busy_drain", busy, 1);
    d = 0;
    got = 0;
    while (got < N && d < TIMEOUT) begin
      v = (got < nout) && ($urandom_range(99) >= gap);
      core_out_valid = v;
      core_y_real = 16'($urandom);
      core_y_img = 16'($urandom);
      tb = mode == 2 && ch && got < 6;
      if (tb) begin
        core_y_real = 16'(tbl[got].yr);
        core_y_img = 16'(tbl[got].yi);
        er = tbl[got].eor;
        ei = tbl[got].eoi;
      end else if (ch) begin
        er = floor256(core_y_real);
        ei = floor256(sat_neg(core_y_img));
      end else begin
        er = core_y_real;
        ei = core_y_img;
      end
      tick();
      d++;
      chk("gnt_drain", gnt, 0);
      chk("o_valid", o_valid, v);
      chk("o_last", o_last, v && got == N - 1);
      if (v) begin
        chk("o_real", o_real, er);
        chk("o_img", o_img, ei);
        chk("o_ch", o_ch, ch);
        got++;
      end
      chk("err_drain", err, got < N && d == TIMEOUT);
      chk("busy_drain_end", busy, !(got == N || d == TIMEOUT));
    end
    core_out_valid = 1'b0;
    if (got < N) begin
      tick();
      chk("err_pulse_width", err, 0);
    end
    m_rr = !ch;
  endtask

  initial begin
    tbl[0] = '{100, 5, 100, -5, 25600, 512, 100, -2};
    tbl[1] = '{0, -32768, 0, 32767, -256, -32768, -1, 127};
    tbl[2] = '{-32768, 32767, -32768, -32767, 255, 255, 0, -1};
    tbl[3] = '{1, -1, 1, 1, -1, 1, -1, -1};
    tbl[4] = '{7, 0, 7, 0, 32767, -32767, 127, 127};
    tbl[5] = '{-5, -32767, -5, 32767, -32768, 0, -128, 0};
    rst_n = 1'b1;
    req = 2'b11;
    ch_valid = 2'b11;
    ch0_real = 16'sd77;
    ch0_img = -16'sd9;
    ch1_real = 16'sd300;
    ch1_img = 16'sd41;
    core_out_valid = 1'b1;
    core_y_real = 16'sd5;
    core_y_img = 16'sd6;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    core_out_valid = 1'b0;
    ch_valid = 2'b00;
    req = 2'b00;
    tick();
    tick();
    chk_all_zero("reset_held");
    #2 rst_n = 1'b1;
    m_rr = 1'b0;
    frame(2'b01, 0, N, 1, 1'b1, -1);
    frame(2'b10, 30, N, 2, 1'b1, -1);
    frame(2'b11, 50, N, 0, 1'b0, -1);
    frame(2'b11, 50, N, 0, 1'b0, -1);
    frame(2'b11, 50, N, 0, 1'b1, -1);
    tick();
    core_out_valid = 1'b1;
    core_y_real = 16'sd1234;
    tick();
    chk("stray_err", err, 1);
    chk("stray_o_valid", o_valid, 0);
    core_out_valid = 1'b0;
    tick();
    chk("stray_err_clear", err, 0);
    chk("stray_busy", busy, 0);
    frame(2'b01, 20, 10, 0, 1'b1, -1);
    frame(2'b11, 20, N, 0, 1'b1, -1);
    frame(2'b11, 10, N, 0, 1'b1, 100);
    frame(2'b11, 0, N, 1, 1'b1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
